// File: rtl/cpu_program_loader.sv
// Host-side loader for the FRANK6000 core: packs a byte stream into 16-bit words,
// writes them to instruction memory, then runs the CPU until halt or cycle budget.
module cpu_program_loader #(
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [8:0]  i_len,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [15:0] o_instr,
  output logic [7:0]  o_instr_addr,
  output logic        o_we,
  output logic        o_ON,
  output logic        o_cpu_rst,
  input  logic        i_loopf,
  input  logic [7:0]  i_WREG,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [7:0]  o_result,
  output logic [15:0] o_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HI,
    S_LOAD_LO,
    S_WRITE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [15:0] MaxCnt = 16'(MAX_CYCLES);

  state_t      state_q, state_d;
  logic [8:0]  len_q, len_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  result_q, result_d;
  logic [15:0] cycles_q, cycles_d;
  logic [15:0] cnt_inc;

  assign cnt_inc = cnt_q + 16'd1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    index_d   = index_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    // The run counter idles at zero, so RUN is always entered with cnt==0.
    cnt_d     = (state_q == S_RUN) ? cnt_q : '0;
    timeout_d = timeout_q;
    result_d  = result_q;
    cycles_d  = cycles_q;

    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            timeout_d = 1'b0;
            result_d  = '0;
            cycles_d  = '0;
            index_d   = '0;
            len_d     = (i_len > 9'd256) ? 9'd256 : i_len;
            state_d   = (i_len == 9'd0) ? S_RUN : S_LOAD_HI;
          end
        end
        S_LOAD_HI: begin
          if (i_byte_valid) begin
            hi_d    = i_byte;
            state_d = S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          if (i_byte_valid) begin
            lo_d    = i_byte;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if ({1'b0, index_q} == len_q - 9'd1) begin
            state_d = S_RUN;
          end else begin
            index_d = index_q + 8'd1;
            state_d = S_LOAD_HI;
          end
        end
        S_RUN: begin
          // Halt is checked first so it wins over a coincident budget expiry.
          if (i_loopf) begin
            result_d = i_WREG;
            cycles_d = cnt_q;
            state_d  = S_DONE;
          end else if (cnt_inc == MaxCnt) begin
            timeout_d = 1'b1;
            cycles_d  = MaxCnt;
            state_d   = S_DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous and active-high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      index_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      index_q   <= index_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      cycles_q  <= cycles_d;
    end
  end

  always_comb begin
    o_cpu_rst    = (state_q != S_RUN);
    o_ON         = (state_q == S_RUN);
    o_byte_ready = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO);
    o_we         = (state_q == S_WRITE);
    o_instr      = (state_q == S_WRITE) ? {hi_q, lo_q} : 16'h0000;
    o_instr_addr = (state_q == S_WRITE) ? index_q : 8'h00;
    o_busy       = (state_q != S_IDLE);
    o_done       = (state_q == S_DONE);
  end

  assign o_timeout = timeout_q;
  assign o_result  = result_q;
  assign o_cycles  = cycles_q;

endmodule
